// File: rtl/pooling_pkg.sv
// pooling_pkg: shared types, FSM states and window origin table for pooling_2x2.
package pooling_pkg;
    localparam int DATA_W  = 16;
    localparam int LATENCY = 5;
    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic signed [DATA_W+1:0] sum_t;
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
    // Window w covers rows WIN_ROW[w]..+1, columns WIN_COL[w]..+1 of the tile
    localparam logic [2:0] WIN_ROW [4] = '{3'd0, 3'd0, 3'd2, 3'd2};
    localparam logic [2:0] WIN_COL [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
endpackage

// File: rtl/pooling_2x2_window.sv
// pool_window_2x2: combinational 2x2 window operator.
// Truncating average by default; signed maximum when POOL_MAX_EN is defined.
module pool_window_2x2
    import pooling_pkg::*;
(
    input  pixel_t p0,
    input  pixel_t p1,
    input  pixel_t p2,
    input  pixel_t p3,
    output pixel_t y
);
`ifdef POOL_MAX_EN
    pixel_t m01, m23;
    always_comb begin
        m01 = (p0 > p1) ? p0 : p1;
        m23 = (p2 > p3) ? p2 : p3;
        y   = (m01 > m23) ? m01 : m23;
    end
`else
    sum_t s;
    // Bias negative sums by 3 so the arithmetic shift rounds toward zero
    always_comb begin
        s = sum_t'(p0) + sum_t'(p1) + sum_t'(p2) + sum_t'(p3);
        y = pixel_t'(((s < 0) ? s + sum_t'(3) : s) >>> 2);
    end
`endif
endmodule

// File: rtl/pooling_2x2.sv
// pooling_2x2: 5x5 tile -> 2x2 stride-2 pooling with level start/finish handshake.
// Window operator selected by POOL_MAX_EN (max) or default truncating average.
module pooling_2x2
    import pooling_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] px_0_0, px_0_1, px_0_2, px_0_3, px_0_4,
    input  logic signed [DATA_W-1:0] px_1_0, px_1_1, px_1_2, px_1_3, px_1_4,
    input  logic signed [DATA_W-1:0] px_2_0, px_2_1, px_2_2, px_2_3, px_2_4,
    input  logic signed [DATA_W-1:0] px_3_0, px_3_1, px_3_2, px_3_3, px_3_4,
    input  logic signed [DATA_W-1:0] px_4_0, px_4_1, px_4_2, px_4_3, px_4_4,
    output logic                     finish,
    output logic signed [DATA_W-1:0] pixel_out,
    output logic signed [DATA_W-1:0] pool_0_0,
    output logic signed [DATA_W-1:0] pool_0_1,
    output logic signed [DATA_W-1:0] pool_1_0,
    output logic signed [DATA_W-1:0] pool_1_1
);
    pixel_t px [5][5];
    pixel_t tile_q [5][5], tile_d [5][5];
    pixel_t stage_q [4], stage_d [4];
    pixel_t pool_q [4], pool_d [4];
    state_t state_q, state_d;
    logic [1:0] w_q, w_d;
    logic [2:0] r, c;
    pixel_t win;

    assign px = '{'{px_0_0, px_0_1, px_0_2, px_0_3, px_0_4},
                  '{px_1_0, px_1_1, px_1_2, px_1_3, px_1_4},
                  '{px_2_0, px_2_1, px_2_2, px_2_3, px_2_4},
                  '{px_3_0, px_3_1, px_3_2, px_3_3, px_3_4},
                  '{px_4_0, px_4_1, px_4_2, px_4_3, px_4_4}};

    assign r = WIN_ROW[w_q];
    assign c = WIN_COL[w_q];

    pool_window_2x2 u_win (
        .p0 (tile_q[r][c]),
        .p1 (tile_q[r][c + 3'd1]),
        .p2 (tile_q[r + 3'd1][c]),
        .p3 (tile_q[r + 3'd1][c + 3'd1]),
        .y  (win)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        tile_d  = tile_q;
        stage_d = stage_q;
        pool_d  = pool_q;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: begin
                state_d = start ? CALC : IDLE;
                tile_d  = px;
                w_d     = '0;
            end
            CALC: begin
                stage_d[w_q] = win;
                w_d          = w_q + 2'd1;
                state_d      = !start ? IDLE : (w_q == 2'd3) ? DONE : CALC;
                // Last window lands in staging and all four commit together
                if (start && w_q == 2'd3) pool_d = stage_d;
            end
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            tile_q  <= '{default: '0};
            stage_q <= '{default: '0};
            pool_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            tile_q  <= tile_d;
            stage_q <= stage_d;
            pool_q  <= pool_d;
        end
    end

    assign finish    = (state_q == DONE);
    assign pixel_out = pool_q[0];
    assign pool_0_0  = pool_q[0];
    assign pool_0_1  = pool_q[1];
    assign pool_1_0  = pool_q[2];
    assign pool_1_1  = pool_q[3];
endmodule

// File: tb/tb_pooling_2x2.sv
// tb_pooling_2x2: directed and random checks of pooling_2x2 against a plain-arithmetic model.
module tb_pooling_2x2;
    logic clk = 0;
    logic rst_n = 0;
    logic start = 0;
    logic signed [15:0] px [5][5];
    logic finish;
    logic signed [15:0] pixel_out;
    logic signed [15:0] pool_o [4];
    int checks = 0;
    int errors = 0;
    int tm [5][5];
    int exp_pool [4];

    always #5 clk = ~clk;

    pooling_2x2 dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .px_0_0(px[0][0]), .px_0_1(px[0][1]), .px_0_2(px[0][2]), .px_0_3(px[0][3]), .px_0_4(px[0][4]),
        .px_1_0(px[1][0]), .px_1_1(px[1][1]), .px_1_2(px[1][2]), .px_1_3(px[1][3]), .px_1_4(px[1][4]),
        .px_2_0(px[2][0]), .px_2_1(px[2][1]), .px_2_2(px[2][2]), .px_2_3(px[2][3]), .px_2_4(px[2][4]),
        .px_3_0(px[3][0]), .px_3_1(px[3][1]), .px_3_2(px[3][2]), .px_3_3(px[3][3]), .px_3_4(px[3][4]),
        .px_4_0(px[4][0]), .px_4_1(px[4][1]), .px_4_2(px[4][2]), .px_4_3(px[4][3]), .px_4_4(px[4][4]),
        .finish(finish), .pixel_out(pixel_out),
        .pool_0_0(pool_o[0]), .pool_0_1(pool_o[1]), .pool_1_0(pool_o[2]), .pool_1_1(pool_o[3])
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int op4(input int a, input int b, input int c, input int d);
`ifdef POOL_MAX_EN
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
`else
        return (a + b + c + d) / 4;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tile();
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) px[i][j] = '0;
    endtask

    task automatic scramble();
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) px[i][j] = 16'($urandom);
    endtask

    task automatic snapshot_model();
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) tm[i][j] = px[i][j];
        for (int w = 0; w < 4; w++) begin
            int r0 = 2 * (w / 2);
            int c0 = 2 * (w % 2);
            exp_pool[w] = op4(tm[r0][c0], tm[r0][c0+1], tm[r0+1][c0], tm[r0+1][c0+1]);
        end
    endtask

    task automatic check_pools(input string tag);
        chk({tag, "_pixel_out"}, pixel_out, exp_pool[0]);
        for (int w = 0; w < 4; w++) chk($sformatf("%s_pool%0d", tag, w), pool_o[w], exp_pool[w]);
    endtask

    // Full transaction: start high 10 cycles, low 10 cycles; tile inputs scrambled after LOAD
    task automatic run_txn(input string tag);
        snapshot_model();
        start = 1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk($sformatf("%s_finish_e%0d", tag, i), finish, (i == 5) ? 1 : 0);
            if (i == 1) scramble();
        end
        check_pools(tag);
        repeat (4) tick();
        chk({tag, "_finish_hold"}, finish, 1);
        start = 0;
        tick();
        chk({tag, "_finish_fall"}, finish, 0);
        repeat (9) tick();
        chk({tag, "_hold_pool11"}, pool_o[3], exp_pool[3]);
    endtask

    initial begin
        int saved [4];
        clear_tile();
        #12;
        chk("rst_finish", finish, 0);
        chk("rst_pixel_out", pixel_out, 0);
        for (int w = 0; w < 4; w++) chk($sformatf("rst_pool%0d", w), pool_o[w], 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        px[0][0] = 10; px[0][1] = 20; px[1][0] = 30; px[1][1] = 41;
`ifdef POOL_MAX_EN
        chk("dir_basic_model", op4(10, 20, 30, 41), 41);
`else
        chk("dir_basic_model", op4(10, 20, 30, 41), 25);
`endif
        run_txn("basic");

        clear_tile();
        px[0][0] = -1; px[0][1] = -2; px[1][0] = -3; px[1][1] = -1;
        for (int i = 2; i < 4; i++) for (int j = 2; j < 4; j++) px[i][j] = -16'sd32768;
        run_txn("neg");
        chk("neg_pixel_out_const", pixel_out, -1);
        chk("neg_pool11_const", pool_o[3], -32768);

        clear_tile();
        px[0][0] = 5; px[0][1] = -7; px[1][0] = 99; px[1][1] = 3;
        run_txn("mix");
`ifdef POOL_MAX_EN
        chk("mix_const", pixel_out, 99);
`else
        chk("mix_const", pixel_out, 25);
`endif

        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) px[i][j] = 16'($urandom_range(99));
            run_txn($sformatf("rnd%0d", t));
        end

        // Abort: drop start during the second CALC cycle; committed values must survive
        for (int w = 0; w < 4; w++) saved[w] = exp_pool[w];
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) px[i][j] = 16'($urandom_range(99));
        start = 1;
        repeat (3) tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("abort_finish%0d", i), finish, 0);
        end
        for (int w = 0; w < 4; w++) chk($sformatf("abort_pool%0d", w), pool_o[w], saved[w]);

        // Reset in the middle of CALC
        start = 1;
        repeat (3) tick();
        rst_n = 0;
        #1;
        chk("midrst_finish", finish, 0);
        chk("midrst_pixel_out", pixel_out, 0);
        for (int w = 0; w < 4; w++) chk($sformatf("midrst_pool%0d", w), pool_o[w], 0);
        start = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (7) tick();
        chk("midrst_idle_finish", finish, 0);
        chk("midrst_idle_pool0", pool_o[0], 0);

        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) px[i][j] = 16'($urandom_range(99));
        run_txn("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pooling_2x2.md
# pooling_2x2

Fixed-geometry 2x2 pooling engine for the CNN datapath. Accepts a 5x5 tile of signed 16-bit pixels, computes the four stride-2 2x2 windows that fit the tile (row/col 4 discarded) and presents the pooled 2x2 result with a level-based start/finish handshake. The top-left window result is also driven on a dedicated scalar output for single-pixel consumers.

## Interface
- DATA_W, 16, pixel width (signed two's complement)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request; held high for the whole transaction
- px_R_C (R,C = 0..4, 25 ports, ordered px_0_0, px_0_1 … px_4_4)  in  DATA_W  tile pixel at row R, column C
- finish  out  1  high while results are valid and start is still high
- pixel_out  out  DATA_W  pooled window (0,0) = pool_0_0
- pool_0_0, pool_0_1, pool_1_0, pool_1_1  out  DATA_W each  pooled window at input origin (2i, 2j)

## Operation
- FSM states: IDLE, LOAD, CALC, DONE.
- IDLE: finish=0. start=1 → LOAD.
- LOAD (1 cycle): register all 25 pixels into an internal tile; later input changes are ignored until the next transaction. → CALC, window index w=0.
- CALC (4 cycles): one window per cycle, order (0,0),(0,2),(2,0),(2,2); result written into a staging register. After w=3 → DONE, committing all four staging values to pool_* simultaneously.
- DONE: finish=1 while start=1; start=0 → IDLE.
- start falling during LOAD/CALC: abort to IDLE; pool_* keep their previous committed values; finish never rises.
- Average arithmetic: sum of four pixels in DATA_W+2 signed bits; divide by 4 truncating toward zero (sum<0: add 3 then arithmetic shift right 2; else arithmetic shift right 2). Result always fits DATA_W; no saturation needed.
- Outputs hold their values in IDLE until the next commit.

## Timing
- Reset (async assert, sync deassert handled by system): state=IDLE, finish=0, pixel_out=0, all pool_*=0, staging and tile registers 0.
- start sampled high at edge k: LOAD at k, CALC at k+1..k+4, finish=1 and pool_* valid after edge k+5 (5-cycle latency).
- start sampled low in DONE at edge m: finish=0 after edge m.
- start re-asserted in the same cycle finish falls: no effect until sampled in IDLE (next edge) → new transaction.
- rst_n asserted mid-transaction: immediate return to reset values, no commit.

## Configuration
- POOL_MAX_EN defined: window operator is signed maximum of the four pixels (no adder/shift).
- POOL_MAX_EN undefined (default): truncating average as above. Timing and handshake identical in both builds.

## Structure
- Package pooling_pkg: pixel_t (signed DATA_W), sum_t (signed DATA_W+2), state enum, WIN_ROW/WIN_COL origin constants {0,0,2,2}/{0,2,0,2}, LATENCY=5.
- Sub-module pool_window_2x2: combinational, four pixel_t in, one pixel_t out; contains the POOL_MAX_EN selection. Instantiated once, fed by a tile mux indexed by w.

## Test plan
- Reset: rst_n=0 → finish=0, pixel_out=0, all pool_*=0.
- px_0_0..px_1_1 = 10,20,30,41, start held → after 5 edges finish=1, pixel_out=25; start=0 → finish=0 next edge.
- Negative truncation: window (0,0) = -1,-2,-3,-1 (sum -7) → pixel_out=-1 (not -2); window (2,2) = -32768×4 → pool_1_1=-32768.
- 300 random tiles (0..99), start high 10 cycles then low 10 cycles → pixel_out and each pool_i_j equal model average of their window; finish timing per Timing each time.
- Abort and reset: drop start at CALC cycle 2 → finish stays 0, pool_* unchanged; assert rst_n=0 in CALC → outputs 0, FSM IDLE.
- POOL_MAX_EN build: window (0,0) = 5,-7,99,3 → pixel_out=99, latency still 5.
